// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and constants for the multicycle controller: FSM states,
// instruction classes, opcode/aluop/immsel codes and ALU status bit positions.
package multicycle_ctrl_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_e;

    typedef enum logic [2:0] {
        CLS_R   = 3'd0,
        CLS_I   = 3'd1,
        CLS_LW  = 3'd2,
        CLS_SW  = 3'd3,
        CLS_B   = 3'd4,
        CLS_ILL = 3'd5
    } instr_cls_e;

    localparam logic [6:0] OPC_R  = 7'b0110011;
    localparam logic [6:0] OPC_I  = 7'b0010011;
    localparam logic [6:0] OPC_LW = 7'b0000011;
    localparam logic [6:0] OPC_SW = 7'b0100011;
    localparam logic [6:0] OPC_B  = 7'b1100011;

    localparam logic [3:0] ALUOP_ADD = 4'b0000;
    localparam logic [3:0] ALUOP_BR  = 4'b1000;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;

    localparam int STAT_N = 3;
    localparam int STAT_Z = 2;
    localparam int STAT_C = 1;
    localparam int STAT_V = 0;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;
    localparam logic [2:0] F3_BLT = 3'b100;
    localparam logic [2:0] F3_BGE = 3'b101;
    localparam logic [2:0] F3_SRX = 3'b101;

    function automatic logic branch_f3_valid(input logic [2:0] f3);
        return (f3 == F3_BEQ) || (f3 == F3_BNE) || (f3 == F3_BLT) || (f3 == F3_BGE);
    endfunction

    function automatic logic branch_taken(input logic [2:0] f3, input logic [3:0] st);
        logic lt;
        lt = st[STAT_N] ^ st[STAT_V];
        case (f3)
            F3_BEQ:  return st[STAT_Z];
            F3_BNE:  return !st[STAT_Z];
            F3_BLT:  return lt;
            F3_BGE:  return !lt;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Signal bundle between the multicycle controller and its datapath/memory side.
interface multicycle_ctrl_if (
    input logic clk
);
    import multicycle_ctrl_pkg::*;

    logic [31:0] instr;
    logic [3:0]  status;
    logic        mem_ready;
    logic        mem_req;
    logic        memrw;
    logic        ir_we;
    logic        pc_we;
    logic        pcsrc;
    logic [3:0]  aluop;
    logic [1:0]  immsel;
    logic        alusrc;
    logic        regrw;
    logic        wb;
    logic [2:0]  state;
    logic        illegal;
    logic [15:0] instret;

    // Controller side
    modport master (
        input  clk, instr, status, mem_ready,
        output mem_req, memrw, ir_we, pc_we, pcsrc, aluop, immsel, alusrc,
               regrw, wb, state, illegal, instret
    );

    // Datapath / memory side
    modport slave (
        input  clk, mem_req, memrw, ir_we, pc_we, pcsrc, aluop, immsel, alusrc,
               regrw, wb, state, illegal, instret,
        output instr, status, mem_ready
    );

endinterface

// File: rtl/multicycle_ctrl_decode.sv
// Combinational instruction decoder: IR fields to ALU controls and instruction class.
module ctrl_decode
    import multicycle_ctrl_pkg::*;
(
    input  logic [31:0] ir_i,
    output logic [3:0]  aluop_o,
    output logic [1:0]  immsel_o,
    output logic        alusrc_o,
    output instr_cls_e  cls_o
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       unused_ir_bits;

    assign opcode         = ir_i[6:0];
    assign funct3         = ir_i[14:12];
    assign funct7_5       = ir_i[30];
    assign unused_ir_bits = ^{ir_i[31], ir_i[29:15], ir_i[11:7]};

    always_comb begin
        aluop_o  = ALUOP_ADD;
        immsel_o = IMM_I;
        alusrc_o = 1'b0;
        cls_o    = CLS_ILL;
        case (opcode)
            OPC_R: begin
                cls_o   = CLS_R;
                aluop_o = {funct7_5, funct3};
            end
            OPC_I: begin
                // Only shift-right immediates use bit 30 to pick arithmetic vs logical
                cls_o    = CLS_I;
                alusrc_o = 1'b1;
                aluop_o  = {((funct3 == F3_SRX) && funct7_5), funct3};
            end
            OPC_LW: begin
                cls_o    = CLS_LW;
                alusrc_o = 1'b1;
            end
            OPC_SW: begin
                cls_o    = CLS_SW;
                alusrc_o = 1'b1;
                immsel_o = IMM_S;
            end
            OPC_B: begin
                cls_o    = CLS_B;
                aluop_o  = ALUOP_BR;
                immsel_o = IMM_B;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM (FETCH/DECODE/EXEC/MEM/WB) with instruction
// register, sticky illegal flag and retired-instruction counter.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic [3:0]  status,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        memrw,
    output logic        ir_we,
    output logic        pc_we,
    output logic        pcsrc,
    output logic [3:0]  aluop,
    output logic [1:0]  immsel,
    output logic        alusrc,
    output logic        regrw,
    output logic        wb,
    output logic [2:0]  state,
    output logic        illegal,
    output logic [15:0] instret
);

    state_e      state_q, state_d;
    logic [31:0] ir_q, ir_d;
    logic        illegal_q, illegal_d;
    logic [15:0] instret_q, instret_d;
    logic        retire;
    logic        br_valid;
    logic        br_taken;
    instr_cls_e  cls;
    logic        unused_carry;

    ctrl_decode u_decode (
        .ir_i     (ir_q),
        .aluop_o  (aluop),
        .immsel_o (immsel),
        .alusrc_o (alusrc),
        .cls_o    (cls)
    );

    assign br_valid     = branch_f3_valid(ir_q[14:12]);
    assign br_taken     = branch_taken(ir_q[14:12], status);
    assign unused_carry = status[STAT_C];

    // Pulses depend on same-cycle mem_ready/status, so they are decoded from the
    // registered state rather than registered themselves.
    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        illegal_d = illegal_q;
        instret_d = instret_q;
        mem_req   = 1'b0;
        memrw     = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pcsrc     = 1'b0;
        regrw     = 1'b0;
        wb        = 1'b0;
        retire    = 1'b0;
        case (state_q)
            FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_we   = 1'b1;
                    ir_d    = instr;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                if (cls == CLS_ILL) begin
                    pc_we     = 1'b1;
                    illegal_d = 1'b1;
                    state_d   = FETCH;
                end else begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                case (cls)
                    CLS_R, CLS_I:   state_d = WB;
                    CLS_LW, CLS_SW: state_d = MEM;
                    CLS_B: begin
                        pc_we   = 1'b1;
                        retire  = 1'b1;
                        pcsrc   = br_valid & br_taken;
                        state_d = FETCH;
                        if (!br_valid) begin
                            illegal_d = 1'b1;
                        end
                    end
                    default: state_d = FETCH;
                endcase
            end
            MEM: begin
                mem_req = 1'b1;
                memrw   = (cls == CLS_SW);
                if (mem_ready) begin
                    if (cls == CLS_SW) begin
                        pc_we   = 1'b1;
                        retire  = 1'b1;
                        state_d = FETCH;
                    end else begin
                        state_d = WB;
                    end
                end
            end
            WB: begin
                regrw   = 1'b1;
                wb      = (cls == CLS_LW);
                pc_we   = 1'b1;
                retire  = 1'b1;
                state_d = FETCH;
            end
            default: state_d = FETCH;
        endcase
        if (retire) begin
            instret_d = instret_q + 16'd1;
        end
        // An instruction aborted by reset must not commit anything
        if (reset) begin
            ir_we = 1'b0;
            pc_we = 1'b0;
            pcsrc = 1'b0;
            regrw = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= FETCH;
            ir_q      <= 32'd0;
            illegal_q <= 1'b0;
            instret_q <= 16'd0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            illegal_q <= illegal_d;
            instret_q <= instret_d;
        end
    end

    assign state   = state_q;
    assign illegal = illegal_q;
    assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: expected per-instruction behaviour is
// queued when an instruction is presented and checked when the DUT retires it.
module tb_multicycle_ctrl;
    import multicycle_ctrl_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    multicycle_ctrl_if bus (.clk(clk));

    multicycle_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .instr     (bus.instr),
        .status    (bus.status),
        .mem_ready (bus.mem_ready),
        .mem_req   (bus.mem_req),
        .memrw     (bus.memrw),
        .ir_we     (bus.ir_we),
        .pc_we     (bus.pc_we),
        .pcsrc     (bus.pcsrc),
        .aluop     (bus.aluop),
        .immsel    (bus.immsel),
        .alusrc    (bus.alusrc),
        .regrw     (bus.regrw),
        .wb        (bus.wb),
        .state     (bus.state),
        .illegal   (bus.illegal),
        .instret   (bus.instret)
    );

    typedef struct {
        string       name;
        int          latency;
        logic [63:0] trace;
        logic        pcsrc;
        logic [3:0]  aluop;
        logic        alusrc;
        logic [1:0]  immsel;
        logic        chk_alu;
        logic        chk_imm;
        int          regrw;
        logic        wb;
        int          memrw;
        logic        ill;
        logic        retire;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          failures = 0;
    logic [15:0] exp_instret = 16'd0;
    logic        exp_illegal = 1'b0;

    function automatic logic [63:0] app(input logic [63:0] t, input logic [2:0] s);
        return {t[60:0], s};
    endfunction

    function automatic exp_t model(input string name, input logic [31:0] ins,
                                   input logic [3:0] st, input int stall);
        exp_t e;
        logic [2:0] f3;
        logic n, z, v;
        f3 = ins[14:12];
        n = st[3]; z = st[2]; v = st[0];
        e.name = name; e.pcsrc = 1'b0; e.aluop = 4'b0000; e.alusrc = 1'b0;
        e.immsel = 2'b00; e.chk_alu = 1'b1; e.chk_imm = 1'b1; e.regrw = 0;
        e.wb = 1'b0; e.memrw = 0; e.ill = 1'b0; e.retire = 1'b1;
        e.trace = 64'd1;
        case (ins[6:0])
            7'b0110011: begin
                e.latency = 4; e.aluop = {ins[30], f3}; e.chk_imm = 1'b0; e.regrw = 1;
                e.trace = app(app(e.trace, 3'd2), 3'd4);
            end
            7'b0010011: begin
                e.latency = 4; e.aluop = {(f3 == 3'b101) ? ins[30] : 1'b0, f3};
                e.alusrc = 1'b1; e.regrw = 1;
                e.trace = app(app(e.trace, 3'd2), 3'd4);
            end
            7'b0000011: begin
                e.latency = 5 + stall; e.alusrc = 1'b1; e.regrw = 1; e.wb = 1'b1;
                e.trace = app(e.trace, 3'd2);
                for (int i = 0; i <= stall; i++) e.trace = app(e.trace, 3'd3);
                e.trace = app(e.trace, 3'd4);
            end
            7'b0100011: begin
                e.latency = 4 + stall; e.alusrc = 1'b1; e.immsel = 2'b01; e.memrw = stall + 1;
                e.trace = app(e.trace, 3'd2);
                for (int i = 0; i <= stall; i++) e.trace = app(e.trace, 3'd3);
            end
            7'b1100011: begin
                e.latency = 3; e.aluop = 4'b1000; e.immsel = 2'b10;
                e.trace = app(e.trace, 3'd2);
                case (f3)
                    3'b000:  e.pcsrc = z;
                    3'b001:  e.pcsrc = !z;
                    3'b100:  e.pcsrc = n ^ v;
                    3'b101:  e.pcsrc = !(n ^ v);
                    default: e.ill = 1'b1;
                endcase
            end
            default: begin
                e.latency = 2; e.ill = 1'b1; e.retire = 1'b0;
                e.chk_alu = 1'b0; e.chk_imm = 1'b0;
            end
        endcase
        return e;
    endfunction

    // Presents one instruction starting in FETCH and runs it to its pc_we pulse.
    task automatic run_instr(input string name, input logic [31:0] ins,
                             input logic [3:0] st, input int stall);
        exp_t        e;
        logic [63:0] trace;
        int          lat, regrw_cnt, memrw_cnt, stall_left;
        logic        pcsrc_obs, wb_obs, done, stable, src_obs;
        logic [3:0]  alu_obs;
        logic [1:0]  imm_obs;
        sb_q.push_back(model(name, ins, st, stall));
        bus.instr = ins;
        stall_left = stall; trace = 64'd0; lat = 0; regrw_cnt = 0; memrw_cnt = 0;
        pcsrc_obs = 1'b0; wb_obs = 1'b0; done = 1'b0; stable = 1'b1;
        src_obs = 1'b0; alu_obs = 4'd0; imm_obs = 2'd0;
        for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
            bus.mem_ready = !(bus.state == MEM && stall_left > 0);
            if (bus.state == MEM && stall_left > 0) stall_left--;
            bus.status = (bus.state == EXEC) ? st : ~st;
            #1;
            trace = app(trace, bus.state);
            lat = cyc;
            if (bus.state == DECODE) begin
                alu_obs = bus.aluop; src_obs = bus.alusrc; imm_obs = bus.immsel;
            end else if (bus.state inside {EXEC, MEM, WB}) begin
                if (bus.aluop !== alu_obs || bus.alusrc !== src_obs || bus.immsel !== imm_obs)
                    stable = 1'b0;
            end
            if (bus.regrw) begin regrw_cnt++; wb_obs = bus.wb; end
            if (bus.memrw) memrw_cnt++;
            if (bus.pc_we) begin done = 1'b1; pcsrc_obs = bus.pcsrc; end
            @(posedge clk); #1;
        end
        e = sb_q.pop_front();
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL %s timeout: no pc_we within 40 cycles, required latency %0d", e.name, e.latency);
            return;
        end
        checks++; if (lat !== e.latency) begin failures++; $display("FAIL %s latency: got %0d required %0d", e.name, lat, e.latency); end
        checks++; if (trace !== e.trace) begin failures++; $display("FAIL %s states: got %0o required %0o", e.name, trace, e.trace); end
        checks++; if (pcsrc_obs !== e.pcsrc) begin failures++; $display("FAIL %s pcsrc: got %b required %b", e.name, pcsrc_obs, e.pcsrc); end
        checks++; if (regrw_cnt !== e.regrw) begin failures++; $display("FAIL %s regrw cycles: got %0d required %0d", e.name, regrw_cnt, e.regrw); end
        checks++; if (memrw_cnt !== e.memrw) begin failures++; $display("FAIL %s memrw cycles: got %0d required %0d", e.name, memrw_cnt, e.memrw); end
        if (e.regrw > 0) begin
            checks++; if (wb_obs !== e.wb) begin failures++; $display("FAIL %s wb: got %b required %b", e.name, wb_obs, e.wb); end
        end
        if (e.chk_alu) begin
            checks++; if (alu_obs !== e.aluop) begin failures++; $display("FAIL %s aluop: got %b required %b", e.name, alu_obs, e.aluop); end
            checks++; if (src_obs !== e.alusrc) begin failures++; $display("FAIL %s alusrc: got %b required %b", e.name, src_obs, e.alusrc); end
            checks++; if (stable !== 1'b1) begin failures++; $display("FAIL %s ctrl_stable: got %b required 1", e.name, stable); end
        end
        if (e.chk_imm) begin
            checks++; if (imm_obs !== e.immsel) begin failures++; $display("FAIL %s immsel: got %b required %b", e.name, imm_obs, e.immsel); end
        end
        if (e.retire) exp_instret++;
        if (e.ill) exp_illegal = 1'b1;
        checks++; if (bus.state !== 3'd0) begin failures++; $display("FAIL %s end_state: got %0d required 0", e.name, bus.state); end
        checks++; if (bus.illegal !== exp_illegal) begin failures++; $display("FAIL %s illegal: got %b required %b", e.name, bus.illegal, exp_illegal); end
        checks++; if (bus.instret !== exp_instret) begin failures++; $display("FAIL %s instret: got %h required %h", e.name, bus.instret, exp_instret); end
        $display("txn %-10s instr=%h lat=%0d pcsrc=%b instret=%h illegal=%b", e.name, ins, lat, pcsrc_obs, bus.instret, bus.illegal);
    endtask

    task automatic test_reset();
        reset = 1'b1; bus.mem_ready = 1'b0; bus.instr = 32'd0; bus.status = 4'd0;
        repeat (2) @(posedge clk);
        #1; reset = 1'b0;
        exp_instret = 16'd0; exp_illegal = 1'b0;
        #1;
        checks++; if (bus.state !== 3'd0) begin failures++; $display("FAIL reset state: got %0d required 0", bus.state); end
        checks++; if (bus.mem_req !== 1'b1) begin failures++; $display("FAIL reset mem_req: got %b required 1", bus.mem_req); end
        checks++; if (bus.instret !== 16'd0) begin failures++; $display("FAIL reset instret: got %h required 0000", bus.instret); end
        checks++; if (bus.illegal !== 1'b0) begin failures++; $display("FAIL reset illegal: got %b required 0", bus.illegal); end
        checks++; if ({bus.pc_we, bus.regrw, bus.memrw, bus.ir_we} !== 4'b0000) begin
            failures++; $display("FAIL reset pulses: got %b required 0000", {bus.pc_we, bus.regrw, bus.memrw, bus.ir_we});
        end
        $display("txn reset      state=%0d mem_req=%b instret=%h illegal=%b", bus.state, bus.mem_req, bus.instret, bus.illegal);
    endtask

    task automatic test_alu();
        run_instr("addi", 32'h00400093, 4'h0, 0);
        run_instr("sub", 32'h40000033, 4'h0, 0);
        run_instr("srai", 32'h40105093, 4'h0, 0);
        run_instr("ori_b30", 32'h40006093, 4'h0, 0);
        run_instr("add", 32'h000000B3, 4'h0, 0);
    endtask

    task automatic test_mem();
        run_instr("lw", 32'h00002003, 4'h0, 0);
        run_instr("lw_stall", 32'h00002003, 4'h0, 2);
        run_instr("sw_stall", 32'h00100023, 4'h0, 3);
        run_instr("sw", 32'h00100023, 4'h0, 0);
    endtask

    task automatic test_branch();
        run_instr("beq_t", 32'h40210463, 4'b0100, 0);
        run_instr("beq_nt", 32'h40210463, 4'b0000, 0);
        run_instr("bne_t", 32'h00001063, 4'b0000, 0);
        run_instr("blt_t", 32'h00004063, 4'b1000, 0);
        run_instr("blt_nt", 32'h00004063, 4'b1001, 0);
        run_instr("bge_t", 32'h00005063, 4'b0000, 0);
        run_instr("bge_nt", 32'h00005063, 4'b1000, 0);
    endtask

    task automatic test_illegal();
        run_instr("illegal", 32'hFFFFFFFF, 4'h0, 0);
        run_instr("addi_stky", 32'h00400093, 4'h0, 0);
    endtask

    task automatic test_bad_branch();
        run_instr("b_badf3", 32'h00002063, 4'b0100, 0);
    endtask

    task automatic test_wrap();
        bus.mem_ready = 1'b0;
        force dut.instret_q = 16'hFFFF;
        @(posedge clk); #1;
        release dut.instret_q;
        @(posedge clk); #1;
        checks++; if (bus.instret !== 16'hFFFF) begin failures++; $display("FAIL preload instret: got %h required ffff", bus.instret); end
        exp_instret = 16'hFFFF;
        run_instr("add_wrap", 32'h000000B3, 4'h0, 0);
    endtask

    task automatic test_reset_mid_mem();
        int guard;
        bus.instr = 32'h00100023; bus.mem_ready = 1'b1;
        guard = 0;
        while (bus.state != MEM && guard < 10) begin
            @(posedge clk); #1; guard++;
        end
        checks++;
        if (bus.state != MEM) begin
            failures++; $display("FAIL midmem reach_mem: got state %0d required 3", bus.state);
            return;
        end
        bus.mem_ready = 1'b0; #1;
        checks++; if ({bus.mem_req, bus.memrw} !== 2'b11) begin failures++; $display("FAIL midmem req: got %b required 11", {bus.mem_req, bus.memrw}); end
        reset = 1'b1; bus.mem_ready = 1'b1; #1;
        checks++; if (bus.pc_we !== 1'b0) begin failures++; $display("FAIL midmem pc_we_in_reset: got %b required 0", bus.pc_we); end
        @(posedge clk); #1;
        reset = 1'b0; bus.mem_ready = 1'b0; exp_instret = 16'd0; #1;
        checks++; if (bus.state !== 3'd0) begin failures++; $display("FAIL midmem state: got %0d required 0", bus.state); end
        checks++; if (bus.instret !== exp_instret) begin failures++; $display("FAIL midmem instret: got %h required %h", bus.instret, exp_instret); end
        checks++; if ({bus.pc_we, bus.regrw, bus.mem_req} !== 3'b001) begin
            failures++; $display("FAIL midmem pulses: got %b required 001", {bus.pc_we, bus.regrw, bus.mem_req});
        end
        $display("txn reset_mem  state=%0d instret=%h pc_we=%b", bus.state, bus.instret, bus.pc_we);
    endtask

    initial begin
        bus.instr = 32'd0; bus.status = 4'd0; bus.mem_ready = 1'b0;
        test_reset();
        test_alu();
        test_mem();
        test_branch();
        test_illegal();
        test_reset();
        test_bad_branch();
        test_wrap();
        test_reset_mid_mem();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
